digit_pixel_gen: RTL

- Pixel source feeding the VGA timing block's `rIn/gIn/bIn`. Consumes that block's `hj`, `vj`, `hDisplay` and `vDisplay`.
- Renders a row of seven-segment glyphs from a double-buffered digit register file. Writes from the calculator core go to a back buffer; the back buffer is copied to the front buffer at the start of vertical blanking, so the image never tears.
- Output is registered, 2-cycle pipeline, 1 bit per colour.

---
 rtl/digit_pixel_pkg.sv | 39 +++
 rtl/digit_seg_lut.sv | 16 +
 rtl/digit_pixel_gen.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/digit_pixel_pkg.sv
// Shared constants for the seven-segment pixel generator: glyph codes, segment masks, default geometry.
// Latency: none (constants only).
// Backpressure: not applicable.
package digit_pixel_pkg;

   // Glyph codes that are not decimal digits
   localparam logic [3:0] GLYPH_BLANK = 4'hA;
   localparam logic [3:0] GLYPH_MINUS = 4'hB;

   // Segment masks indexed by glyph code, bit order {g,f,e,d,c,b,a}
   localparam logic [15:0][6:0] SEG_MASK = {
      7'h00,   // F blank
      7'h00,   // E blank
      7'h00,   // D blank
      7'h00,   // C blank
      7'h40,   // B minus
      7'h00,   // A blank
      7'h6F,   // 9
      7'h7F,   // 8
      7'h07,   // 7
      7'h7D,   // 6
      7'h6D,   // 5
      7'h66,   // 4
      7'h4F,   // 3
      7'h5B,   // 2
      7'h06,   // 1
      7'h3F    // 0
   };

   // Default geometry
   localparam int DEF_NUM_DIGITS = 8;
   localparam int DEF_ORIGIN_X   = 140;
   localparam int DEF_ORIGIN_Y   = 206;
   localparam int DEF_DIGIT_W    = 42;
   localparam int DEF_DIGIT_H    = 70;
   localparam int DEF_GAP        = 6;
   localparam int DEF_SEG_T      = 6;

endpackage

// File: rtl/digit_seg_lut.sv
// Glyph code to seven-segment mask lookup.
// Latency: combinational.
// Backpressure: none.
module digit_seg_lut
   import digit_pixel_pkg::*;
(
   input  logic [3:0] code,
   output logic [6:0] segmask
);

   // Pure table lookup
   always_comb begin
      segmask = SEG_MASK[code];
   end

endmodule

// File: rtl/digit_pixel_gen.sv
// Seven-segment digit row pixel source with double-buffered digit registers; optional cursor via DIGIT_PIXEL_GEN_CURSOR_EN.
// Latency: 2 clocks from hj/vj/hDisplay/vDisplay to rOut/gOut/bOut.
// Backpressure: none; writes are accepted every cycle, out-of-range slots are dropped.
module digit_pixel_gen
   import digit_pixel_pkg::*;
#(
   parameter int          NUM_DIGITS = DEF_NUM_DIGITS,
   parameter int          AW         = $clog2(NUM_DIGITS),
   parameter int          ORIGIN_X   = DEF_ORIGIN_X,
   parameter int          ORIGIN_Y   = DEF_ORIGIN_Y,
   parameter int          DIGIT_W    = DEF_DIGIT_W,
   parameter int          DIGIT_H    = DEF_DIGIT_H,
   parameter int          GAP        = DEF_GAP,
   parameter int          SEG_T      = DEF_SEG_T,
   parameter logic [2:0]  FG         = 3'b111,
   parameter logic [2:0]  BG         = 3'b000
)(
   input  logic          clk,
   input  logic          reset,
   input  logic [10:0]   hj,
   input  logic [20:0]   vj,
   input  logic          hDisplay,
   input  logic          vDisplay,
   input  logic          wr_en,
   input  logic [AW-1:0] wr_addr,
   input  logic [3:0]    wr_data,
`ifdef DIGIT_PIXEL_GEN_CURSOR_EN
   input  logic [AW-1:0] cursor_pos,
`endif
   output logic          swap_pulse,
   output logic          rOut,
   output logic          gOut,
   output logic          bOut
);

   localparam int M = DIGIT_H / 2;
`ifdef DIGIT_PIXEL_GEN_CURSOR_EN
   localparam int V_WIN = DIGIT_H + SEG_T;
`else
   localparam int V_WIN = DIGIT_H;
`endif

   logic [3:0] back  [NUM_DIGITS];
   logic [3:0] front [NUM_DIGITS];
   logic       vd_q;

   // Only the low 10 line bits address the screen
   logic unused_vj;
   assign unused_vj = ^vj[20:10];

   // Front buffer reloads on the falling edge of vDisplay
   assign swap_pulse = vd_q & ~vDisplay;

   // vDisplay history for the edge detector
   always_ff @(posedge clk or posedge reset) begin
      if (reset) vd_q <= 1'b0;
      else       vd_q <= vDisplay;
   end

   // Back buffer writes and front buffer copy; front sees pre-write back contents
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < NUM_DIGITS; i++) begin
            back[i]  <= GLYPH_BLANK;
            front[i] <= GLYPH_BLANK;
         end
      end else begin
         if (swap_pulse) front <= back;
         for (int i = 0; i < NUM_DIGITS; i++) begin
            if (wr_en && (32'(wr_addr) == i)) back[i] <= wr_data;
         end
      end
   end

`ifdef DIGIT_PIXEL_GEN_CURSOR_EN
   logic [4:0] blink_cnt;

   // Blink phase advances once per frame
   always_ff @(posedge clk or posedge reset) begin
      if (reset)           blink_cnt <= 5'd0;
      else if (swap_pulse) blink_cnt <= blink_cnt + 5'd1;
   end
`endif

   // Stage 1 combinational: slot selection and local coordinates
   logic       hit_d;
   logic [5:0] lx_d;
   logic [6:0] ly_d;
   logic [3:0] code_d;
   logic       cur_d;
   int         hx;
   int         vy;
   int         x0;

   // Parallel window compare across all slots
   always_comb begin
      hit_d  = 1'b0;
      lx_d   = '0;
      ly_d   = '0;
      code_d = GLYPH_BLANK;
      cur_d  = 1'b0;
      x0     = 0;
      hx     = 32'(hj);
      vy     = 32'(vj[9:0]);
      if (vy >= ORIGIN_Y && vy < ORIGIN_Y + V_WIN) begin
         ly_d = 7'(vy - ORIGIN_Y);
         for (int i = 0; i < NUM_DIGITS; i++) begin
            x0 = ORIGIN_X + i * (DIGIT_W + GAP);
            if (hx >= x0 && hx < x0 + DIGIT_W) begin
               hit_d  = 1'b1;
               lx_d   = 6'(hx - x0);
               code_d = front[i];
`ifdef DIGIT_PIXEL_GEN_CURSOR_EN
               cur_d  = (32'(cursor_pos) == i);
`endif
            end
         end
      end
   end

   logic       s1_hit;
   logic       s1_act;
   logic [5:0] s1_lx;
   logic [6:0] s1_ly;
   logic [3:0] s1_code;
   logic       s1_cur;

   // Stage 1 register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         s1_hit  <= 1'b0;
         s1_act  <= 1'b0;
         s1_lx   <= '0;
         s1_ly   <= '0;
         s1_code <= GLYPH_BLANK;
         s1_cur  <= 1'b0;
      end else begin
         s1_hit  <= hit_d;
         s1_act  <= hDisplay & vDisplay;
         s1_lx   <= lx_d;
         s1_ly   <= ly_d;
         s1_code <= code_d;
         s1_cur  <= cur_d;
      end
   end

   logic [6:0] segmask;

   digit_seg_lut u_lut (
      .code    (s1_code),
      .segmask (segmask)
   );

   // Stage 2 combinational: segment geometry, bit order {g,f,e,d,c,b,a}
   logic [6:0] geom;
   logic       under;
   logic       lit;
   int         lx_i;
   int         ly_i;

   // Segments are confined to the glyph body so the cursor band never lights d/c/e
   always_comb begin
      geom  = '0;
      under = 1'b0;
      lx_i  = 32'(s1_lx);
      ly_i  = 32'(s1_ly);
      if (ly_i < DIGIT_H) begin
         geom[0] = (ly_i < SEG_T);
         geom[1] = (lx_i >= DIGIT_W - SEG_T) && (ly_i < M);
         geom[2] = (lx_i >= DIGIT_W - SEG_T) && (ly_i >= M);
         geom[3] = (ly_i >= DIGIT_H - SEG_T);
         geom[4] = (lx_i < SEG_T) && (ly_i >= M);
         geom[5] = (lx_i < SEG_T) && (ly_i < M);
         geom[6] = (ly_i >= M - SEG_T / 2) && (ly_i < M + SEG_T / 2);
      end
`ifdef DIGIT_PIXEL_GEN_CURSOR_EN
      under = s1_cur && !blink_cnt[4] &&
              (ly_i >= DIGIT_H + SEG_T / 2) && (ly_i < DIGIT_H + SEG_T);
`else
      under = s1_cur & 1'b0;
`endif
      lit = s1_hit && (((segmask & geom) != 7'd0) || under);
   end

   // Stage 2 register: colour, forced black outside the active area
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         {rOut, gOut, bOut} <= 3'b000;
      end else if (s1_act) begin
         {rOut, gOut, bOut} <= lit ? FG : BG;
      end else begin
         {rOut, gOut, bOut} <= 3'b000;
      end
   end

endmodule
